// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates two bus masters onto one synchronous-read, byte-write word RAM.
//   Port 0 is the CPU native memory bus and port 1 is a peripheral master.
//   Each accepted request performs exactly one RAM access. The sequence is
//   IDLE -> ACCESS -> DONE -> IDLE, so a transaction whose valid is sampled
//   in IDLE cycle T completes with a one-cycle ready pulse in cycle T+2.
//   When both ports request together, the port that was not served last
//   wins. A request whose word index lies beyond the RAM is absorbed: the
//   RAM is never enabled for it, a read returns zero, and err pulses
//   together with ready.
//
// Ports
//   clk, resetn          clock; synchronous active-low reset
//   m0_valid/addr/wdata/wstrb  port 0 request (wstrb == 0 means read)
//   m0_ready, m0_rdata   port 0 completion pulse and read data
//   m1_*                 same set for port 1
//   ram_en, ram_we, ram_addr, ram_wdata   RAM macro command
//   ram_rdata            RAM read data, one cycle after ram_en
//   busy                 transaction in progress
//   grant_id             port owning the current or last transaction
//   err                  out-of-range transaction completing this cycle
module mem_port_arbiter #(
  parameter  int MEM_SIZE = 4096,
  localparam int AW       = $clog2(MEM_SIZE),
  localparam int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              m0_valid,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_valid,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,

  output logic              busy,
  output logic              grant_id,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic                oor_q, oor_d;
  logic                ram_en_q, ram_en_d;
  logic [3:0]          ram_we_q, ram_we_d;
  logic [AW-1:0]       ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

  logic                sel;
  logic [31:0]         sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [3:0]          sel_wstrb;
  logic                sel_oor;
  logic                in_done;
  logic [DATA_W-1:0]   rd_word;
  logic                unused_addr_lsbs;

  // Word index beyond the RAM depth; the full upper address is compared so
  // aliases of low addresses are rejected too.
  function automatic logic out_of_range(input logic [31:0] addr);
    return ({2'b00, addr[31:2]} >= 32'(MEM_SIZE));
  endfunction

  // A lone requester wins outright; on a tie the port not served last wins.
  assign sel       = (m0_valid && m1_valid) ? ~last_grant_q : m1_valid;
  assign sel_addr  = sel ? m1_addr  : m0_addr;
  assign sel_wdata = sel ? m1_wdata : m0_wdata;
  assign sel_wstrb = sel ? m1_wstrb : m0_wstrb;
  assign sel_oor   = out_of_range(sel_addr);

  // Byte offset within the word carries no meaning for a word RAM.
  assign unused_addr_lsbs = ^sel_addr[1:0];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    oor_d        = oor_q;
    ram_en_d     = ram_en_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    case (state_q)
      S_IDLE: begin
        ram_en_d = 1'b0;
        ram_we_d = 4'b0000;
        if (m0_valid || m1_valid) begin
          grant_d     = sel;
          ram_addr_d  = sel_addr[AW+1:2];
          ram_wdata_d = sel_wdata;
          oor_d       = sel_oor;
          ram_en_d    = !sel_oor;
          ram_we_d    = sel_oor ? 4'b0000 : sel_wstrb;
          state_d     = S_ACCESS;
        end
      end
      // RAM samples the command at the edge closing this cycle.
      S_ACCESS: begin
        ram_en_d = 1'b0;
        ram_we_d = 4'b0000;
        state_d  = S_DONE;
      end
      // Read data from the RAM is present now; ready is decoded below.
      S_DONE: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: begin
        ram_en_d = 1'b0;
        ram_we_d = 4'b0000;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      oor_q        <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 4'b0000;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      oor_q        <= oor_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign in_done   = (state_q == S_DONE);
  assign rd_word   = oor_q ? '0 : ram_rdata;

  assign m0_ready  = in_done && !grant_q;
  assign m1_ready  = in_done &&  grant_q;
  assign m0_rdata  = m0_ready ? rd_word : '0;
  assign m1_rdata  = m1_ready ? rd_word : '0;

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  assign busy      = (state_q != S_IDLE);
  assign grant_id  = grant_q;
  assign err       = in_done && oor_q;

endmodule
